// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FAULT} fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction
endpackage

// File: rtl/ifetch_skid_buf.sv
// Two-entry valid/ready buffer (output register plus one skid entry) with flush.
// The output register only changes when empty or popped, so data holds under stall.
module ifetch_skid_buf #(
  parameter int W = 65
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   count
);
  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         pop;

  assign pop   = out_valid && out_ready;
  assign count = 2'(out_valid) + 2'(skid_valid);

  always_ff @(posedge gclk) begin
    if (!grst_n || flush) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (pop || !out_valid) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= in_valid;
        if (in_valid) skid_data <= in_data;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end else if (in_valid) begin
      // Issue credit guarantees the skid entry is free here.
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, X/Y memory addressing, 2-entry output buffering, redirects.
// Optional out-of-range PC fault handling is compiled in with IFETCH_FAULT_EN.
module instr_fetch_unit #(
  parameter int          ADDR_BITS  = 8,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic [ADDR_BITS-1:0]  X_addr,
  output logic [ADDR_BITS-1:0]  Y_addr,
  output logic                  ReadEnable,
  output logic                  WriteEnable,
  output logic [DATA_WIDTH-1:0] Data_in,
  input  logic [DATA_WIDTH-1:0] Data_out,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [31:0]           instr_pc,
  output logic                  instr_fault
);
  import ifetch_pkg::*;

  localparam int HALF = ADDR_BITS / 2;
  localparam int EW   = DATA_WIDTH + 33;

  fetch_state_e           state;
  logic [31:0]            pc;
  logic                   inflight;
  logic [31:0]            inflight_pc;
  logic [ADDR_BITS-1:0]   word_idx;
  logic                   out_of_range;
  logic                   pop;
  logic [1:0]             occ;
  logic [2:0]             load;
  logic                   want;
  logic                   issue;
  logic                   fault_push;
  logic                   push_valid;
  logic [EW-1:0]          push_data;
  logic [EW-1:0]          head;
  logic                   head_fault;
  logic                   unused_pc_lsb;

  assign word_idx    = pc[ADDR_BITS+1:2];
  assign X_addr      = ADDR_BITS'(word_idx[ADDR_BITS-1:HALF]);
  assign Y_addr      = ADDR_BITS'(word_idx[HALF-1:0]);
  assign WriteEnable = 1'b0;
  assign Data_in     = '0;

`ifdef IFETCH_FAULT_EN
  assign out_of_range = |pc[31:ADDR_BITS+2];
`else
  assign out_of_range = 1'b0;
`endif

  // Entries already held plus the one arriving, minus the one leaving, must stay below 2.
  assign pop        = instr_valid && instr_ready;
  assign load       = 3'(occ) + 3'(inflight) - 3'(pop);
  assign want       = Reset_n && !redirect_valid && fetch_en && (state != FAULT) && (load < 3'd2);
  assign issue      = want && !out_of_range;
  assign fault_push = want && out_of_range && !inflight;
  assign ReadEnable = issue;

  assign push_valid = (inflight && !redirect_valid) || fault_push;
  assign push_data  = inflight ? {1'b0, inflight_pc, Data_out}
                               : {1'b1, pc, DATA_WIDTH'(NOP_INSTR)};

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) inflight_pc <= pc;

      if (redirect_valid)  pc <= {redirect_pc[31:2], 2'b00};
      else if (issue)      pc <= next_pc(pc);

      if (fault_push) state <= FAULT;
      else begin
        case (state)
          IDLE:  if (fetch_en) state <= RUN;
          RUN:   if (!fetch_en) state <= DRAIN;
          DRAIN: if (fetch_en) state <= RUN;
                 else if (!inflight) state <= IDLE;
          FAULT: if (redirect_valid) state <= fetch_en ? RUN : IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  ifetch_skid_buf #(.W(EW)) u_skid (
    .gclk      (Clock),
    .grst_n    (Reset_n),
    .flush     (redirect_valid),
    .in_valid  (push_valid),
    .in_data   (push_data),
    .out_valid (instr_valid),
    .out_data  (head),
    .out_ready (instr_ready),
    .count     (occ)
  );

  assign instr      = head[DATA_WIDTH-1:0];
  assign instr_pc   = head[DATA_WIDTH+31:DATA_WIDTH];
  assign head_fault = head[EW-1];

`ifdef IFETCH_FAULT_EN
  assign instr_fault = head_fault;
  assign unused_pc_lsb = ^redirect_pc[1:0];
`else
  assign instr_fault = 1'b0;
  assign unused_pc_lsb = ^{redirect_pc[1:0], head_fault};
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a synchronous X/Y memory model (mem[i] = i + 0x100).
module tb_instr_fetch_unit;
`ifdef IFETCH_FAULT_EN
  localparam bit FAULT_BUILD = 1'b1;
`else
  localparam bit FAULT_BUILD = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset_n, fetch_en, redirect_valid, instr_ready;
  logic [31:0] redirect_pc;
  logic [7:0]  X_addr, Y_addr;
  logic        ReadEnable, WriteEnable;
  logic [31:0] Data_in, Data_out;
  logic        instr_valid, instr_fault;
  logic [31:0] instr, instr_pc;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_pc;

  instr_fetch_unit #(.ADDR_BITS(8), .DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .X_addr(X_addr), .Y_addr(Y_addr), .ReadEnable(ReadEnable),
    .WriteEnable(WriteEnable), .Data_in(Data_in), .Data_out(Data_out),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .instr_fault(instr_fault)
  );

  always #5 Clock = ~Clock;

  // Read data only in the cycle after a request; garbage otherwise.
  always @(posedge Clock)
    Data_out <= ReadEnable ? (32'h100 + {24'h0, X_addr[3:0], Y_addr[3:0]}) : 32'hDEAD_BEEF;

  function automatic logic [31:0] exp_instr(input logic [31:0] p);
    if (FAULT_BUILD && p[31:10] != 22'h0) return 32'h13;
    return 32'h100 + {24'h0, p[9:2]};
  endfunction

  function automatic logic exp_fault(input logic [31:0] p);
    return FAULT_BUILD && (p[31:10] != 22'h0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // One cycle; every accepted instruction is checked against the expected stream.
  task automatic tick();
    @(negedge Clock);
    if (instr_valid && instr_ready) begin
      chk("acc_instr", instr, exp_instr(exp_pc));
      chk("acc_pc", instr_pc, exp_pc);
      chk("acc_fault", 32'(instr_fault), 32'(exp_fault(exp_pc)));
      exp_pc += 32'd4;
    end
    @(posedge Clock); #1;
  endtask

  initial begin
    Reset_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    instr_ready = 1'b1; exp_pc = '0;
    tick(); tick();
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_re", 32'(ReadEnable), 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_fault", 32'(instr_fault), 0);
    chk("rst_we", 32'(WriteEnable), 0);
    chk("rst_din", Data_in, 0);
    Reset_n = 1'b1;
    tick();

    // Streaming from reset
    fetch_en = 1'b1; #1;
    chk("t1_re", 32'(ReadEnable), 1);
    chk("t1_x", 32'(X_addr), 0);
    chk("t1_y", 32'(Y_addr), 0);
    tick(); chk("t1_lat", 32'(instr_valid), 0);
    tick();
    chk("t1_first_v", 32'(instr_valid), 1);
    chk("t1_first_i", instr, 32'h100);
    chk("t1_first_pc", instr_pc, 0);
    for (int i = 0; i < 5; i++) begin tick(); chk("t1_b2b", 32'(instr_valid), 1); end

    // Back-pressure
    instr_ready = 1'b0; #1;
    chk("t2_re_drop", 32'(ReadEnable), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_v", 32'(instr_valid), 1);
      chk("t2_hold_i", instr, exp_instr(exp_pc));
      chk("t2_hold_pc", instr_pc, exp_pc);
      chk("t2_re", 32'(ReadEnable), 0);
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin tick(); chk("t2_cont", 32'(instr_valid), 1); end

    // Redirect with a request in flight
    redirect_valid = 1'b1; redirect_pc = 32'h23; #1;
    chk("t3_re_off", 32'(ReadEnable), 0);
    tick();
    redirect_valid = 1'b0; exp_pc = 32'h20; #1;
    chk("t3_v0", 32'(instr_valid), 0);
    chk("t3_re", 32'(ReadEnable), 1);
    chk("t3_y", 32'(Y_addr), 8);
    tick(); chk("t3_v1", 32'(instr_valid), 0);
    tick();
    chk("t3_v", 32'(instr_valid), 1);
    chk("t3_i", instr, 32'h108);
    chk("t3_pc", instr_pc, 32'h20);

    // Top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'h3F0;
    tick();
    redirect_valid = 1'b0; exp_pc = 32'h3F0; #1;
    for (int k = 0; k < 4; k++) begin
      chk("t4_x", 32'(X_addr), 15);
      chk("t4_y", 32'(Y_addr), 32'(12 + k));
      tick();
    end
    if (FAULT_BUILD) chk("t4_re_fault", 32'(ReadEnable), 0);
    else begin
      chk("t4_re_wrap", 32'(ReadEnable), 1);
      chk("t4_x_wrap", 32'(X_addr), 0);
      chk("t4_y_wrap", 32'(Y_addr), 0);
    end
    for (int i = 0; i < 8; i++) tick();
    chk("t4_seen_400", 32'(exp_pc >= 32'h404), 1);
    if (FAULT_BUILD) chk("t4_fault_idle", 32'(ReadEnable), 0);

    // fetch_en drop with one request in flight
    redirect_valid = 1'b1; redirect_pc = 32'h40; fetch_en = 1'b1;
    tick();
    redirect_valid = 1'b0; exp_pc = 32'h40;
    tick();
    fetch_en = 1'b0; #1;
    chk("t5_re", 32'(ReadEnable), 0);
    tick();
    chk("t5_v", 32'(instr_valid), 1);
    chk("t5_i", instr, 32'h110);
    chk("t5_pc", instr_pc, 32'h40);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_idle_re", 32'(ReadEnable), 0);
      chk("t5_idle_v", 32'(instr_valid), 0);
    end

    // Reset mid-stream
    fetch_en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("t6_pre_v", 32'(instr_valid), 1);
    instr_ready = 1'b0; Reset_n = 1'b0; #1;
    chk("t6_rst_re", 32'(ReadEnable), 0);
    tick();
    chk("t6_v", 32'(instr_valid), 0);
    chk("t6_i", instr, 0);
    chk("t6_pc", instr_pc, 0);
    Reset_n = 1'b1; instr_ready = 1'b1; exp_pc = 32'h0; #1;
    chk("t6_re", 32'(ReadEnable), 1);
    chk("t6_x", 32'(X_addr), 0);
    chk("t6_y", 32'(Y_addr), 0);
    tick(); chk("t6_lat", 32'(instr_valid), 0);
    tick();
    chk("t6_first_v", 32'(instr_valid), 1);
    chk("t6_first_i", instr, 32'h100);
    chk("t6_first_pc", instr_pc, 0);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
